// File: rtl/split_rx.sv
// Serial frame receiver: oversamples sclk_n/cs_n/sdi on clk and assembles MSB-first words.
// Define SPLIT_RX_SYNC_EN to add two-flop synchronizers on all three inputs.
module split_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_a_n,
    input  logic             ena,
    input  logic             sclk_n,
    input  logic             cs_n,
    input  logic             sdi,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

    logic s_sclk, s_cs, s_sdi;

`ifdef SPLIT_RX_SYNC_EN
    logic [1:0] sclk_q, cs_q, sdi_q;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            sclk_q <= 2'b11;
            cs_q   <= 2'b11;
            sdi_q  <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[0], sclk_n};
            cs_q   <= {cs_q[0], cs_n};
            sdi_q  <= {sdi_q[0], sdi};
        end
    end

    assign s_sclk = sclk_q[1];
    assign s_cs   = cs_q[1];
    assign s_sdi  = sdi_q[1];
`else
    assign s_sclk = sclk_n;
    assign s_cs   = cs_n;
    assign s_sdi  = sdi;
`endif

    logic             sclk_prev;
    logic             fall;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] sh;
    logic [WIDTH-1:0] word_next;

    assign fall      = sclk_prev & ~s_sclk;
    assign word_next = {sh, s_sdi};
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) sclk_prev <= 1'b1;
        else          sclk_prev <= s_sclk;
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (!ena) begin
                // Abort: drop whatever frame was in progress, no status pulses.
                state <= IDLE;
                cnt   <= '0;
                sh    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (!s_cs) state <= SHIFT;
                    end
                    SHIFT: begin
                        if (fall) begin
                            sh <= word_next[WIDTH-2:0];
                            if (cnt == LAST) begin
                                // Completing fall wins over a coincident cs_n rise.
                                data  <= word_next;
                                valid <= 1'b1;
                                if (s_cs) begin
                                    state <= IDLE;
                                    cnt   <= '0;
                                end else begin
                                    state <= TAIL;
                                    cnt   <= FULL;
                                end
                            end else if (s_cs) begin
                                frame_err <= 1'b1;
                                state     <= IDLE;
                                cnt       <= '0;
                                sh        <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else if (s_cs) begin
                            frame_err <= (cnt != '0);
                            state     <= IDLE;
                            cnt       <= '0;
                            sh        <= '0;
                        end
                    end
                    TAIL: begin
                        if (fall) overrun <= 1'b1;
                        if (s_cs) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_split_rx.sv
// Bench for split_rx (default build, no synchronizers, WIDTH = 8): table-driven frames
// plus hand-written abort, mid-frame reset and coincident-edge sequences.
module tb_split_rx;
    logic       clk = 1'b0;
    logic       rst_a_n = 1'b0;
    logic       ena = 1'b0;
    logic       sclk_n = 1'b1;
    logic       cs_n = 1'b1;
    logic       sdi = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, overrun, busy;

    split_rx #(.WIDTH(8)) dut (
        .clk(clk), .rst_a_n(rst_a_n), .ena(ena), .sclk_n(sclk_n), .cs_n(cs_n),
        .sdi(sdi), .data(data), .valid(valid), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int val_cnt = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every valid pulse pops one expected word.
    always @(negedge clk) begin
        if (rst_a_n) begin
            if (valid) begin
                val_cnt++;
                if (exp_q.size() == 0) chk("unexpected_valid", {24'h0, data}, 32'hFFFF_FFFF);
                else chk("sb_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
            end
            if (frame_err) err_cnt++;
            if (overrun) ovr_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clr_counts();
        val_cnt = 0; err_cnt = 0; ovr_cnt = 0;
    endtask

    task automatic bit_fall(input logic b);
        sdi = b;
        sclk_n = 1'b1;
        repeat (2) @(negedge clk);
        sclk_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input int n, input logic [15:0] bits);
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            bit_fall(bits[i]);
            if (i == n - 1) chk("busy_mid_frame", {31'h0, busy}, 32'h1);
        end
        sclk_n = 1'b1;
        @(negedge clk);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        string       name;
        int          nfalls;
        logic [15:0] bits;
        int          e_valid;
        int          e_err;
        int          e_ovr;
        logic [7:0]  e_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"basic_a5",  8, 16'h00A5, 1, 0, 0, 8'hA5};
        vecs[1] = '{"b2b_00",    8, 16'h0000, 1, 0, 0, 8'h00};
        vecs[2] = '{"b2b_ff",    8, 16'h00FF, 1, 0, 0, 8'hFF};
        vecs[3] = '{"b2b_3c",    8, 16'h003C, 1, 0, 0, 8'h3C};
        vecs[4] = '{"short_1f",  5, 16'h001F, 0, 1, 0, 8'h3C};
        vecs[5] = '{"long_81",  10, 16'h0204, 1, 0, 2, 8'h81};

        repeat (2) @(negedge clk);
        chk("rst_data", {24'h0, data}, 32'h0);
        chk("rst_flags", {28'h0, valid, frame_err, overrun, busy}, 32'h0);
        rst_a_n = 1'b1;
        @(negedge clk);
        ena = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            clr_counts();
            if (vecs[v].e_valid != 0) exp_q.push_back(vecs[v].e_data);
            send(vecs[v].nfalls, vecs[v].bits);
            chk({vecs[v].name, "_valid"}, val_cnt, vecs[v].e_valid);
            chk({vecs[v].name, "_err"}, err_cnt, vecs[v].e_err);
            chk({vecs[v].name, "_ovr"}, ovr_cnt, vecs[v].e_ovr);
            chk({vecs[v].name, "_data"}, {24'h0, data}, {24'h0, vecs[v].e_data});
            chk({vecs[v].name, "_busy"}, {31'h0, busy}, 32'h0);
        end

        // Abort after 4 bits, then a fresh frame once re-enabled.
        clr_counts();
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) bit_fall(1'b1);
        ena = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        sclk_n = 1'b1;
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_pulses", val_cnt + err_cnt + ovr_cnt, 0);
        chk("abort_data", {24'h0, data}, 32'h81);
        ena = 1'b1;
        @(negedge clk);
        exp_q.push_back(8'h42);
        send(8, 16'h0042);
        chk("reen_valid", val_cnt, 1);
        chk("reen_data", {24'h0, data}, 32'h42);

        // Last fall coincides with cs_n rise: word still completes, no frame error.
        clr_counts();
        exp_q.push_back(8'h5A);
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 7; i >= 1; i--) bit_fall(i[0] ? (8'h5A >> i) & 1 : (8'h5A >> i) & 1);
        sdi = 1'b0;
        sclk_n = 1'b1;
        repeat (2) @(negedge clk);
        sclk_n = 1'b0;
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        sclk_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("coinc_valid", val_cnt, 1);
        chk("coinc_err", err_cnt, 0);
        chk("coinc_data", {24'h0, data}, 32'h5A);
        chk("coinc_busy", {31'h0, busy}, 32'h0);

        // Asynchronous reset mid-frame, then a full frame.
        clr_counts();
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) bit_fall(1'b1);
        #2 rst_a_n = 1'b0;
        #1;
        chk("arst_data", {24'h0, data}, 32'h0);
        chk("arst_flags", {28'h0, valid, frame_err, overrun, busy}, 32'h0);
        @(negedge clk);
        sclk_n = 1'b1;
        cs_n = 1'b1;
        @(negedge clk);
        rst_a_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h99);
        send(8, 16'h0099);
        chk("post_rst_valid", val_cnt, 1);
        chk("post_rst_data", {24'h0, data}, 32'h99);
        chk("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/split_rx.md
# split_rx

Serial frame receiver for the link driven by the `splitter` clock/chip-select generator; it sits at the far end of that link. It oversamples `sclk_n`, `cs_n` and `sdi` on the local system clock, shifts in one `WIDTH`-bit word per frame, MSB first, and presents the word with a one-cycle valid pulse. Short frames are reported as errors; extra bits after a complete word are counted as overrun and dropped.

## Interface
- `WIDTH`, default 8: bits per frame; legal range 2..32.
- `clk`, input, 1: system clock; all state is updated on the rising edge.
- `rst_a_n`, input, 1: asynchronous reset, active low.
- `ena`, input, 1: receiver enable. Low means abort and hold IDLE.
- `sclk_n`, input, 1: serial clock, inverted; idles high.
- `cs_n`, input, 1: frame select, active low.
- `sdi`, input, 1: serial data; valid around the falling edge of `sclk_n`.
- `data`, output, WIDTH: last complete word; holds until the next word arrives.
- `valid`, output, 1: one-cycle pulse when `data` updates.
- `frame_err`, output, 1: one-cycle pulse when a frame ends early.
- `overrun`, output, 1: one-cycle pulse per extra `sclk_n` falling edge after the word is complete.
- `busy`, output, 1: high while the FSM is not in IDLE.

## Operation
- Reset values: `data` = 0, `valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0, FSM = IDLE, bit counter = 0, shift register = 0.
- Input stage: `sclk_n`, `cs_n` and `sdi` pass through the same input stage, so they stay aligned. The synchronizer option is described under Configuration. Reset values: `sclk_n` and `cs_n` stages reset to 1; `sdi` stage resets to 0.
- Edge detect: a fall is previous sampled `sclk_n` = 1 and current sampled `sclk_n` = 0. The previous-sample register resets to 1.
- FSM states:
  - IDLE: bit counter = 0. Sampled `cs_n` = 0 and `ena` = 1 moves to SHIFT.
  - SHIFT:
    - On each fall, shift the register left and load sampled `sdi` into bit 0. Increment the counter.
    - When the counter reaches `WIDTH`, in the same cycle: load `data` with the completed word, pulse `valid`, and go to TAIL.
    - Sampled `cs_n` = 1 with counter in 1..WIDTH-1: pulse `frame_err`, discard the partial word, go to IDLE.
    - Sampled `cs_n` = 1 with counter = 0: go to IDLE silently.
  - TAIL: each fall pulses `overrun`; `data` is unchanged. Sampled `cs_n` = 1 goes to IDLE.
- Simultaneous fall and `cs_n` rise in the same sampled cycle: the fall is processed first. If that fall completes the word, `valid` pulses and the FSM goes to IDLE directly, with no `frame_err`.
- `ena` = 0, any state: the FSM goes to IDLE on the next edge and the counter clears. No `valid`, `frame_err` or `overrun` pulse is produced. Re-enabling mid-frame does not resume the frame: a new frame starts only when the FSM is in IDLE and sampled `cs_n` = 0, so a receiver re-enabled while `cs_n` is held low picks up from the next fall.
- `rst_a_n` asserted mid-frame: all state returns to reset values immediately, without waiting for `clk`.
- Counter width: clog2(WIDTH+1) bits. It never exceeds `WIDTH`; TAIL does not increment it.

## Timing
- `valid`, `frame_err` and `overrun` are registered, each exactly one `clk` cycle wide.
- Latency, with synchronizers: a pin-level `sclk_n` fall before `clk` edge k is processed at edge k+2. `valid` is high in the cycle after edge k+2.
- Latency, without synchronizers: the fall is processed at edge k. `valid` is high in the cycle after edge k.
- Serial clock constraints: each `sclk_n` high phase and low phase must last at least 3 `clk` periods with synchronizers, 2 without.
- `sdi` must be stable 1 `clk` period before and after each `sclk_n` fall.
- `cs_n` setup: at least 2 `clk` periods from `cs_n` fall to the first `sclk_n` fall.
- `cs_n` hold: at least 2 `clk` periods from the last `sclk_n` fall to `cs_n` rise.

## Configuration
- `SPLIT_RX_SYNC_EN` defined: a two-flop synchronizer chain is placed on each of `sclk_n`, `cs_n` and `sdi`. This gives 2 extra cycles of latency and is the setting for inputs asynchronous to `clk`.
- `SPLIT_RX_SYNC_EN` undefined: the inputs are used directly. The edge-detect register is still present. This setting is legal only when the driver runs on `clk`, as in the loopback bench with `splitter`.

## Test plan
- Basic frame: reset, then `ena` = 1, and send 0xA5 with `WIDTH` = 8. Expect `data` = 0xA5, one `valid` pulse, `frame_err` = 0, and `busy` low after the `cs_n` rise.
- Back-to-back frames: send 0x00, 0xFF and 0x3C with 2-cycle `cs_n` gaps. Expect three `valid` pulses with `data` = 0x00, 0xFF and 0x3C, in that order.
- Short frame: send 5 bits of 0x1F, then raise `cs_n`. Expect one `frame_err`, no `valid`, and `data` still holding its previous value.
- Long frame: send 10 falls with the first 8 bits = 0x81. Expect `valid` with `data` = 0x81, then exactly 2 `overrun` pulses.
- Abort:
  - Pull `ena` low after 4 bits. Expect IDLE with no pulses.
  - Re-enable and send 0x42 in a new frame. Expect `data` = 0x42.
- Reset mid-frame: assert `rst_a_n` low after 3 bits. Expect all outputs to return to 0 immediately, and the next full frame 0x99 to give `data` = 0x99.
